detect_top: RTL and testbench



---
 rtl/detect_top_if.sv | 13 +
 rtl/detect_top.sv | 111 +++++++++++
 tb/tb_detect_top.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/detect_top_if.sv
// Pixel-stream bundle between frame source and edge detector: advance, sync flags, pixel in, result out.
interface detect_top_if #(
    parameter int PIXEL_SIZE = 24
);
    logic                  en;
    logic                  hsync;
    logic                  vsync;
    logic [PIXEL_SIZE-1:0] data;
    logic [PIXEL_SIZE-1:0] out;

    modport master (output en, hsync, vsync, data, input out);
    modport slave  (input en, hsync, vsync, data, output out);
endinterface

// File: rtl/detect_top.sv
// BGR pixel stream -> grayscale -> 3x3 Sobel magnitude, three en-gated stages (S1 gray/pos, S2 window, S3 out).
// Define DETECT_THRESHOLD_EN to binarise the magnitude against THRESHOLD.
module detect_top #(
    parameter int         PIXEL_SIZE = 24,
    parameter int         MAX_WIDTH  = 1024,
    parameter logic [7:0] THRESHOLD  = 8'd64
) (
    input logic         clk,
    input logic         reset,
    detect_top_if.slave bus
);
    localparam int CW = $clog2(MAX_WIDTH);

    typedef struct packed {
        logic [7:0]    g;
        logic [CW-1:0] col;
        logic [1:0]    rows;
    } s1_t;

    s1_t                   s1;
    logic [7:0]            gray;
    logic [CW-1:0]         col_n;
    logic [1:0]            rows_n;
    logic [7:0]            lb0 [MAX_WIDTH];
    logic [7:0]            lb1 [MAX_WIDTH];
    logic [2:0][2:0][7:0]  win;   // [row][col], row 0 = top, col 2 = newest
    logic                  ok;
    logic [9:0]            l_sum, r_sum, t_sum, b_sum;
    logic signed [10:0]    gx, gy;
    logic [10:0]           ax, ay;
    logic [11:0]           mag;
    logic [7:0]            m;
    logic [PIXEL_SIZE-1:0] res;

    // Shifts of whole bytes keep the max at 63+127+63 = 253, so no carry out.
    always_comb begin
        gray = (bus.data[23:16] >> 2) + (bus.data[15:8] >> 1) + (bus.data[7:0] >> 2);
    end

    always_comb begin
        col_n  = s1.col;
        rows_n = s1.rows;
        if (bus.vsync) begin
            col_n  = '0;
            rows_n = 2'd1;
        end else if (bus.hsync) begin
            col_n  = '0;
            rows_n = (s1.rows == 2'd3) ? 2'd3 : s1.rows + 2'd1;
        end else if (s1.col != CW'(MAX_WIDTH - 1)) begin
            col_n = s1.col + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
        end else if (bus.en) begin
            s1 <= '{g: gray, col: col_n, rows: rows_n};
        end
    end

    // Line buffers are never cleared; the border flag masks whatever stale data they hold.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            lb1[s1.col] <= lb0[s1.col];
            lb0[s1.col] <= s1.g;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win <= '0;
            ok  <= 1'b0;
        end else if (bus.en) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[s1.col];
            win[1][2] <= lb0[s1.col];
            win[2][2] <= s1.g;
            ok        <= (s1.rows == 2'd3) && (s1.col >= CW'(2));
        end
    end

    always_comb begin
        l_sum = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
        r_sum = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
        t_sum = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};
        b_sum = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
        gx    = $signed({1'b0, r_sum}) - $signed({1'b0, l_sum});
        gy    = $signed({1'b0, b_sum}) - $signed({1'b0, t_sum});
        ax    = gx[10] ? -gx : gx;
        ay    = gy[10] ? -gy : gy;
        mag   = {1'b0, ax} + {1'b0, ay};
        m     = (mag > 12'd255) ? 8'hFF : mag[7:0];
`ifdef DETECT_THRESHOLD_EN
        res   = (m >= THRESHOLD) ? {PIXEL_SIZE{1'b1}} : '0;
`else
        res   = {m, m, m};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out <= '0;
        end else if (bus.en) begin
            bus.out <= ok ? res : '0;
        end
    end
endmodule

// File: tb/tb_detect_top.sv
// Bench for detect_top: 8x8 frames, per-pixel expectations from a frame-level Sobel model queued in a scoreboard.
module tb_detect_top;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [23:0] q[$];
    logic [23:0] last_exp = 24'h0;
    logic [23:0] img [8][8];

    always #5 clk = ~clk;

    detect_top_if #(.PIXEL_SIZE(24)) bus ();

    detect_top #(.PIXEL_SIZE(24), .MAX_WIDTH(1024), .THRESHOLD(8'd64)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic int gray_of(input logic [23:0] p);
        return int'(p[23:16]) / 4 + int'(p[15:8]) / 2 + int'(p[7:0]) / 4;
    endfunction

    function automatic int wt(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    // Expected output for the pixel at (r,c) of the current image.
    function automatic logic [23:0] expect_px(input int r, input int c);
        int gx, gy, m, v;
        gx = 0;
        gy = 0;
        if (r < 2 || c < 2) return 24'h0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v  = gray_of(img[r - 2 + i][c - 2 + j]);
                gx += (j - 1) * wt(i) * v;
                gy += (i - 1) * wt(j) * v;
            end
        end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef DETECT_THRESHOLD_EN
        return (m >= 64) ? 24'hFFFFFF : 24'h0;
`else
        return {3{8'(m)}};
`endif
    endfunction

    task automatic fill(input int split_row, input int split_col,
                        input logic [23:0] a, input logic [23:0] b);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = (r >= split_row && c >= split_col) ? b : a;
    endtask

    task automatic step(input logic hs, input logic vs, input logic [23:0] d, input logic [23:0] ex);
        bus.en    = 1'b1;
        bus.hsync = hs;
        bus.vsync = vs;
        bus.data  = d;
        @(posedge clk);
        #1;
        q.push_back(ex);
        if (q.size() == 3) begin
            last_exp = q.pop_front();
            checks++;
            if (bus.out !== last_exp) begin
                errors++;
                $display("FAIL pipe: out=%h expected %h", bus.out, last_exp);
            end
        end
    endtask

    task automatic run_frame(input int n_px, input int stall_at);
        for (int k = 0; k < n_px; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    bus.en    = 1'b0;
                    bus.hsync = 1'b1;
                    bus.vsync = (s == 2);
                    bus.data  = 24'hA5A5A5;
                    @(posedge clk);
                    #1;
                    checks++;
                    if (bus.out !== last_exp) begin
                        errors++;
                        $display("FAIL stall_hold: out=%h expected %h", bus.out, last_exp);
                    end
                end
            end
            step((k % 8) == 0, k == 0, img[k / 8][k % 8], expect_px(k / 8, k % 8));
        end
    endtask

    task automatic drain();
        step(1'b1, 1'b0, 24'h0, 24'h0);
        step(1'b1, 1'b0, 24'h0, 24'h0);
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0; bus.data = 24'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: out=%h expected %h", bus.out, 24'h0);
        end
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_reset_mid();
        fill(0, 4, 24'h000000, 24'hFFFFFF);
        run_frame(24, -1);
        checks++;
        if (bus.out !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL pre_reset: out=%h expected %h", bus.out, 24'hFFFFFF);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (bus.out !== 24'h0) begin
            errors++;
            $display("FAIL async_reset: out=%h expected %h", bus.out, 24'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        run_frame(64, -1);
    endtask

    task automatic test_uniform();
        fill(0, 0, 24'h808080, 24'h808080);
        run_frame(64, -1);
    endtask

    task automatic test_vertical_edge();
        fill(0, 4, 24'h000000, 24'hFFFFFF);
        run_frame(64, -1);
    endtask

    task automatic test_gray();
        fill(0, 0, 24'h000000, 24'h000000);
        for (int c = 0; c < 8; c++) img[3][c] = 24'hFF0000;
        run_frame(64, -1);
    endtask

    task automatic test_stall();
        fill(0, 4, 24'h000000, 24'hFFFFFF);
        run_frame(64, 20);
    endtask

    task automatic test_back_to_back();
        fill(4, 0, 24'h000000, 24'h000028);
        run_frame(64, -1);
        fill(4, 0, 24'h000000, 24'h000050);
        run_frame(64, -1);
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_uniform();
        test_vertical_edge();
        test_gray();
        test_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
